mysystem_hex_pio_ctrl: RTL
==========================

Name: mysystem_hex_pio_ctrl

Overview:
- Parametrised Avalon-MM output PIO for banks of 7-segment/LED outputs; successor to the single-register HEX output port.
- Provides NUM_CH channels of DATA_W-bit output registers, each with atomic set/clear access and a per-bit hardware blink mask.
- Blink timing comes from an internal prescaler.
- Sits on the system interconnect as a zero-wait-state slave. Each channel's out_port slice drives a group of display segments directly.

Parameters:
- DATA_W, 32, width of each channel register.
- NUM_CH, 2, number of output channels (1..8).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=1).
- RESET_VALUE, 0, reset value of every DATA register.
- Localparams:
  - CH_W = $clog2(NUM_CH+1)
  - ADDR_W = CH_W+2
  - DIV_W = $clog2(BLINK_DIV+1)

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, ADDR_W, word address {ch, reg}.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, DATA_W, write data.
- readdata, output, DATA_W, combinational read data (read latency 0).
- out_port, output, NUM_CH*DATA_W, channel c occupies bits [c*DATA_W +: DATA_W].

Behaviour:
- One clock. Reset is asynchronous and active-low: every register clears on negedge reset_n regardless of clk.
- Write strobe: wr = chipselect & ~write_n. At most one access per cycle.
- Register map, per channel c < NUM_CH, where reg = address[1:0]:
  - reg0 DATA (rw): written with writedata.
  - reg1 SET (w): DATA |= writedata; reads return DATA.
  - reg2 CLEAR (w): DATA &= ~writedata; reads return DATA.
  - reg3 BLINK_MASK (rw).
- Global slot, ch == NUM_CH:
  - reg0 STATUS (ro): bit0 = blink_phase, bit1 = commit_pending, other bits 0.
  - reg1 COMMIT (w): used only with the optional feature.
  - reg2/reg3 read 0; writes ignored.
- ch > NUM_CH: writes ignored, reads 0.
- Write latency: a register updates on the clk edge where wr is sampled high. out_port reflects the new value from that edge onward.
- Read timing: readdata is a pure function of address and register state; chipselect is not required for reads.
- Prescaler: div_cnt counts 0..BLINK_DIV-1 and wraps to 0.
  - On the wrap cycle, blink_phase toggles.
  - BLINK_DIV = 1 toggles blink_phase every cycle.
  - The prescaler is free-running and is not disturbed by register writes.
- Output: out_port[c] = ACTIVE_DATA[c] & ~(BLINK_MASK[c] & {DATA_W{blink_phase}}).
  - Phase 0 = all bits visible.
  - Phase 1 = masked bits driven 0.
- Simultaneous events:
  - A blink toggle in the same cycle as a write: both take effect; out_port uses the new data and the new phase.
  - A write to BLINK_MASK does not reset the prescaler or the phase.
- Reset values:
  - DATA = RESET_VALUE; BLINK_MASK = 0; div_cnt = 0; blink_phase = 0; commit_pending = 0.
  - out_port = RESET_VALUE replicated per channel.
  - readdata = value selected by address.
- Reset asserted mid-count: prescaler restarts from 0, so the first toggle occurs BLINK_DIV cycles after reset release.

Optional Feature:
- Macro: MYSYSTEM_HEX_PIO_COMMIT_EN.
- Defined:
  - DATA, SET and CLEAR write a shadow register; reads return the shadow.
  - ACTIVE_DATA loads all channels' shadows simultaneously on the edge of a COMMIT write, giving tear-free multi-digit updates.
  - commit_pending sets on any shadow write and clears on COMMIT.
  - A shadow write in the same cycle as COMMIT is impossible (single access per cycle).
  - BLINK_MASK is not shadowed.
- Undefined:
  - ACTIVE_DATA is DATA itself.
  - COMMIT writes are ignored.
  - STATUS bit1 reads 0.

Decomposition:
- Package mysystem_hex_pio_pkg holds:
  - register offsets REG_DATA=0, REG_SET=1, REG_CLR=2, REG_BLINK=3;
  - global offsets REG_STATUS=0, REG_COMMIT=1;
  - STATUS bit indices.
- One natural sub-module, mysystem_blink_prescaler, containing the div_cnt counter and blink_phase output (parameter BLINK_DIV).

Test Plan (NUM_CH=2, DATA_W=32, BLINK_DIV=4):
- Reset check: hold reset_n=0 -> out_port=64'h0, STATUS=0. Write DATA0=32'h0000_00FF at addr 0 -> out_port[31:0]=32'h0000_00FF from that edge; reading addr 0 returns 32'hFF.
- SET/CLEAR: SET addr1 with 32'h0000_0F00 -> DATA0=32'h0000_0FFF. CLEAR addr2 with 32'h0000_000F -> DATA0=32'h0000_0FF0. Channel 1 stays 0.
- Blink: DATA1=32'hFFFF_FFFF, BLINK_MASK1=32'h0000_00FF -> out_port[63:32] alternates 32'hFFFF_FFFF / 32'hFFFF_FF00 every 4 cycles; STATUS bit0 tracks phase; first toggle 4 cycles after reset release.
- Out-of-range address: write 32'hDEAD_BEEF to addr 12..15 and addr 10 -> no register changes; reads return 0.
- Reset mid-operation: assert reset_n=0 asynchronously between clk edges during blinking -> out_port=0 immediately; after release, phase 0 for 4 cycles.
- With MYSYSTEM_HEX_PIO_COMMIT_EN: write DATA0=32'h1234, DATA1=32'h5678 -> out_port unchanged and STATUS bit1=1. Write COMMIT (addr 9) -> both channels update on the same edge; bit1=0.

Source files
------------

// File: rtl/mysystem_hex_pio_pkg.sv
// mysystem_hex_pio_pkg: register offsets and STATUS bit positions for the hex PIO controller
package mysystem_hex_pio_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_SET = 2'd1;
  localparam logic [1:0] REG_CLR = 2'd2;
  localparam logic [1:0] REG_BLINK = 2'd3;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_COMMIT = 2'd1;
  localparam int ST_PHASE = 0;
  localparam int ST_PEND = 1;
endpackage

// File: rtl/mysystem_blink_prescaler.sv
// mysystem_blink_prescaler: free-running divider toggling blink_phase every BLINK_DIV clocks
module mysystem_blink_prescaler #(
  parameter int BLINK_DIV = 25000000,
  localparam int DIV_W = $clog2(BLINK_DIV + 1)
) (
  input  logic clk,
  input  logic reset_n,
  output logic blink_phase
);
  logic [DIV_W-1:0] div_cnt;
  logic wrap;
  assign wrap = div_cnt == DIV_W'(BLINK_DIV - 1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      blink_phase <= blink_phase ^ wrap;
    end
  end
endmodule

// File: rtl/mysystem_hex_pio_ctrl.sv
// mysystem_hex_pio_ctrl: multi-channel Avalon-MM output PIO with set/clear and blink masking.
// Define MYSYSTEM_HEX_PIO_COMMIT_EN to shadow DATA and apply all channels together on COMMIT.
module mysystem_hex_pio_ctrl
  import mysystem_hex_pio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 2,
  parameter int BLINK_DIV = 25000000,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0,
  localparam int CH_W = $clog2(NUM_CH + 1),
  localparam int ADDR_W = CH_W + 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);
  logic wr, phase, pend;
  logic [CH_W-1:0] ch;
  logic [1:0] rg;
  logic [DATA_W-1:0] data_a [NUM_CH];
  logic [DATA_W-1:0] mask_a [NUM_CH];
  assign wr = chipselect & ~write_n;
  assign ch = address[ADDR_W-1:2];
  assign rg = address[1:0];
  mysystem_blink_prescaler #(.BLINK_DIV(BLINK_DIV)) u_prescaler (
    .clk(clk),
    .reset_n(reset_n),
    .blink_phase(phase)
  );
`ifdef MYSYSTEM_HEX_PIO_COMMIT_EN
  logic commit;
  assign commit = wr && ch == CH_W'(NUM_CH) && rg == REG_COMMIT;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend <= 1'b0;
    else if (commit) pend <= 1'b0;
    else if (wr && ch < CH_W'(NUM_CH) && rg != REG_BLINK) pend <= 1'b1;
  end
`else
  assign pend = 1'b0;
`endif
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    logic [DATA_W-1:0] data_q, mask_q, act;
    assign sel = wr && ch == CH_W'(c);
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_q <= RESET_VALUE;
        mask_q <= '0;
      end else if (sel) begin
        data_q <= rg == REG_DATA ? writedata :
                  rg == REG_SET  ? data_q | writedata :
                  rg == REG_CLR  ? data_q & ~writedata : data_q;
        if (rg == REG_BLINK) mask_q <= writedata;
      end
    end
`ifdef MYSYSTEM_HEX_PIO_COMMIT_EN
    // data_q is the shadow; the displayed value only moves on COMMIT
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) act <= RESET_VALUE;
      else if (commit) act <= data_q;
    end
`else
    assign act = data_q;
`endif
    assign data_a[c] = data_q;
    assign mask_a[c] = mask_q;
    assign out_port[c*DATA_W +: DATA_W] = act & ~(mask_q & {DATA_W{phase}});
  end
  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == CH_W'(i)) readdata = rg == REG_BLINK ? mask_a[i] : data_a[i];
    if (ch == CH_W'(NUM_CH) && rg == REG_STATUS) begin
      readdata[ST_PHASE] = phase;
      readdata[ST_PEND] = pend;
    end
  end
endmodule
